x_mux_trigger_mc: RTL and testbench

Parametrised successor to the single-channel 32-bit mux trigger. It holds p_chans delay chains of p_taps elements each and launches an edge into a selected channel. The edge is captured at a selected tap, and hits are accumulated over N repeats. A sweep mode finds the first tap where the edge stops arriving. It sits behind x_testbench: the 32-bit control word comes in on i_data and the 32-bit result goes out on o_data, in the 96 MHz PLL domain.

---
 rtl/x_mux_trigger_mc.sv | 179 +++++++++++++++++
 tb/tb_x_mux_trigger_mc.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/x_mux_trigger_mc.sv
// Multi-channel mux trigger: launches an edge into one of p_chans delay chains,
// captures it at a selected tap, counts hits over N repeats, or sweeps taps upward.
// Latency: single 4 cycles, repeat 3N+1, sweep (3N+1)*taps_visited from the accepting edge to done.
// Backpressure: none; go toggles seen while busy are dropped (go_q still tracks i_data[31]).
// Ports: i_clk (96 MHz), i_rst (async active-low), i_data (control word), o_data (status/result).
module x_mux_trigger_mc #(
  parameter int p_chans      = 4,
  parameter int p_taps       = 64,
  parameter int p_model      = 0,
  parameter int p_model_base = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_CAPTURE, S_COMPARE, S_NEXT_TAP, S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic               armed;
  logic               go_q;
  logic [2:0]         mode_q;
  logic [3:0]         ch_q;
  logic [7:0]         tap_q;
  logic [15:0]        n_q;
  logic [15:0]        reps;
  logic [15:0]        hits;
  logic               err_q;
  logic [p_chans-1:0] launch;
  logic               capture;
  logic [15:0]        launch_x;
  logic               mux_out;

  // Request decode
  logic [2:0]  req_mode;
  logic [3:0]  req_ch;
  logic [7:0]  req_tap;
  logic [15:0] req_n;
  logic        req_bad;
  logic        go_edge;

  assign req_mode = i_data[30:28];
  assign req_ch   = i_data[27:24];
  assign req_tap  = i_data[23:16];
  assign req_n    = (req_mode == 3'd0 || i_data[15:0] == 16'd0) ? 16'd1 : i_data[15:0];
  assign req_bad  = (req_mode > 3'd2) || ({1'b0, req_ch} >= 5'(p_chans)) ||
                    ({1'b0, req_tap} >= 9'(p_taps));
  // armed keeps the first post-reset sample of i_data[31] from looking like an edge
  assign go_edge  = armed && (i_data[31] != go_q) && (state == S_IDLE);

  assign launch_x = 16'(launch);

  // Compare / sweep decisions
  logic        cmp_hit;
  logic [15:0] hits_inc;
  logic        last_rep;
  logic        found;
  logic        last_tap;

  assign cmp_hit  = (capture == launch_x[ch_q]);
  assign hits_inc = (cmp_hit && hits != 16'hFFFF) ? hits + 16'd1 : hits;
  assign last_rep = (reps == 16'd1);
  assign found    = ({hits, 1'b0} < {1'b0, n_q});
  assign last_tap = ({1'b0, tap_q} == 9'(p_taps - 1));

  // Tap mux source
  if (p_model == 0) begin : g_lut
    logic [15:0] tap_out;
    for (genvar c = 0; c < 16; c++) begin : g_ch
      if (c < p_chans) begin : g_chain
        logic [255:0] row;
        for (genvar i = 0; i < p_taps; i++) begin : g_tap
          (* keep = "true" *) logic buf_out;
          if (i == 0) begin : g_head
            assign buf_out = launch[c];
          end else begin : g_body
            assign buf_out = g_tap[i-1].buf_out;
          end
          assign row[i] = buf_out;
        end
        if (p_taps < 256) begin : g_pad
          assign row[255:p_taps] = '0;
        end
        assign tap_out[c] = row[tap_q];
      end else begin : g_none
        assign tap_out[c] = 1'b0;
      end
    end
    assign mux_out = tap_out[ch_q];
  end else begin : g_model
    // Capture only follows a toggle, so the previous launch value is always ~launch.
    assign mux_out = (int'(tap_q) < p_model_base + 4 * int'(ch_q)) ? launch_x[ch_q]
                                                                    : ~launch_x[ch_q];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (go_edge) state_nxt = req_bad ? S_FINISH : S_LAUNCH;
      S_LAUNCH:   state_nxt = S_CAPTURE;
      S_CAPTURE:  state_nxt = S_COMPARE;
      S_COMPARE:  begin
        if (!last_rep)            state_nxt = S_LAUNCH;
        else if (mode_q == 3'd2)  state_nxt = S_NEXT_TAP;
        else                      state_nxt = S_FINISH;
      end
      // A terminating sweep publishes directly from here so each visited tap costs 3N+1.
      S_NEXT_TAP: state_nxt = (found || last_tap) ? S_IDLE : S_LAUNCH;
      S_FINISH:   state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      armed   <= 1'b0;
      go_q    <= 1'b0;
      mode_q  <= '0;
      ch_q    <= '0;
      tap_q   <= '0;
      n_q     <= '0;
      reps    <= '0;
      hits    <= '0;
      err_q   <= 1'b0;
      launch  <= '0;
      capture <= 1'b0;
      o_data  <= '0;
    end else begin
      armed <= 1'b1;
      go_q  <= i_data[31];
      case (state)
        S_IDLE: if (go_edge) begin
          mode_q     <= req_mode;
          ch_q       <= req_ch;
          tap_q      <= req_tap;
          n_q        <= req_n;
          reps       <= req_n;
          hits       <= '0;
          err_q      <= req_bad;
          o_data[31] <= 1'b1;
          o_data[30] <= 1'b0;
          o_data[29] <= 1'b0;
        end
        S_LAUNCH: begin
          for (int c = 0; c < p_chans; c++)
            if (ch_q == 4'(c)) launch[c] <= ~launch[c];
        end
        S_CAPTURE: capture <= mux_out;
        S_COMPARE: begin
          hits <= hits_inc;
          reps <= reps - 16'd1;
        end
        S_NEXT_TAP: begin
          if (found)
            o_data <= {1'b0, 1'b1, 1'b0, 1'b0, ch_q, tap_q, hits};
          else if (last_tap)
            o_data <= {1'b0, 1'b1, 1'b0, 1'b0, ch_q, 8'hFF, hits};
          else begin
            tap_q <= tap_q + 8'd1;
            hits  <= '0;
            reps  <= n_q;
          end
        end
        S_FINISH: o_data <= {1'b0, 1'b1, err_q, 1'b0, ch_q, tap_q, hits};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_x_mux_trigger_mc.sv
// Directed bench for x_mux_trigger_mc in behavioural chain mode.
// Expected results and latencies come from a tap-hit model and sit in a scoreboard queue.
// Ports driven: i_clk, i_rst, i_data; o_data compared one time unit after the rising edge.
module tb_x_mux_trigger_mc;
  localparam int CH   = 4;
  localparam int TAPS = 64;
  localparam int BASE = 52;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_data;
  logic [31:0] o_data;

  always #5 clk = ~clk;

  x_mux_trigger_mc #(
    .p_chans(CH), .p_taps(TAPS), .p_model(1), .p_model_base(BASE)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .o_data(o_data)
  );

  int          checks = 0;
  int          errors = 0;
  logic        go = 1'b0;
  logic [3:0]  launch_m = '0;
  logic [31:0] sb_q[$];
  int          lat_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit tap_hits(input int ch, input int tap);
    return tap < BASE + 4 * ch;
  endfunction

  task automatic predict(input int mode, input int ch, input int tap, input int n,
                         output logic [31:0] word, output int lat, output int launches);
    int neff, t, h, visited;
    if (mode > 2 || ch >= CH || tap >= TAPS) begin
      word     = {1'b0, 1'b1, 1'b1, 1'b0, 4'(ch), 8'(tap), 16'd0};
      lat      = 1;
      launches = 0;
    end else begin
      neff = (mode == 0 || n == 0) ? 1 : n;
      if (mode < 2) begin
        h        = tap_hits(ch, tap) ? neff : 0;
        word     = {1'b0, 1'b1, 1'b0, 1'b0, 4'(ch), 8'(tap), 16'(h)};
        lat      = 3 * neff + 1;
        launches = neff;
      end else begin
        t       = tap;
        visited = 0;
        while (1) begin
          visited++;
          h = tap_hits(ch, t) ? neff : 0;
          if (2 * h < neff) begin
            word = {1'b0, 1'b1, 1'b0, 1'b0, 4'(ch), 8'(t), 16'(h)};
            break;
          end
          if (t == TAPS - 1) begin
            word = {1'b0, 1'b1, 1'b0, 1'b0, 4'(ch), 8'hFF, 16'(h)};
            break;
          end
          t++;
        end
        lat      = (3 * neff + 1) * visited;
        launches = neff * visited;
      end
    end
  endtask

  task automatic issue(input int mode, input int ch, input int tap, input int n);
    logic [31:0] w;
    int lat, l;
    predict(mode, ch, tap, n, w, lat, l);
    sb_q.push_back(w);
    lat_q.push_back(lat);
    if (l % 2 == 1) launch_m[ch] = ~launch_m[ch];
    @(negedge clk);
    go     = ~go;
    i_data = {go, 3'(mode), 4'(ch), 8'(tap), 16'(n)};
    @(posedge clk);
    #1;
    check("accept busy/done", {30'd0, o_data[31:30]}, 32'd2);
  endtask

  task automatic wait_done(input string tag, input bit poke);
    logic [31:0] w;
    int lat;
    int k = 0;
    w   = sb_q.pop_front();
    lat = lat_q.pop_front();
    while (k < 3000 && o_data[30] !== 1'b1) begin
      @(posedge clk);
      #1;
      k++;
      if (poke && (k == 10 || k == 20)) i_data[31] = ~i_data[31];
    end
    check({tag, " latency"}, k, lat);
    check({tag, " result"}, o_data, w);
    check({tag, " launch"}, {28'd0, dut.launch}, {28'd0, launch_m});
  endtask

  initial begin
    rst    = 1'b0;
    i_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset o_data", o_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle after release", o_data, 32'd0);

    issue(0, 0, 5, 0);   wait_done("single hit", 0);
    issue(0, 0, 55, 0);  wait_done("single miss", 0);
    issue(0, 1, 2, 7);   wait_done("single ignores N", 0);
    issue(1, 1, 13, 100); wait_done("repeat hit", 0);
    issue(1, 1, 57, 3);  wait_done("repeat miss", 0);
    issue(1, 0, 0, 0);   wait_done("repeat N0", 0);
    issue(2, 2, 50, 4);  wait_done("sweep found", 0);
    issue(2, 3, 60, 1);  wait_done("sweep end", 0);
    issue(5, 0, 5, 1);   wait_done("bad mode", 0);
    issue(0, 7, 5, 1);   wait_done("bad channel", 0);
    issue(0, 0, 64, 1);  wait_done("bad tap", 0);

    issue(1, 1, 3, 50);  wait_done("busy toggles", 1);
    repeat (10) @(posedge clk);
    #1;
    check("one result only", o_data, {1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 8'd3, 16'd50});
    issue(0, 2, 1, 1);   wait_done("after busy toggles", 0);

    issue(2, 0, 0, 4);
    repeat (30) @(posedge clk);
    #1;
    check("sweep running", {31'd0, o_data[31]}, 32'd1);
    rst = 1'b0;
    #1;
    check("reset abort", o_data, 32'd0);
    launch_m = '0;
    sb_q.delete();
    lat_q.delete();
    check("reset launch", {28'd0, dut.launch}, 32'd0);
    go     = 1'b1;
    i_data = {1'b1, 3'd0, 4'd0, 8'd5, 16'd1};
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no start on release", o_data, 32'd0);
    issue(0, 0, 5, 1);   wait_done("after reset", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
